// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the byte-wide RAM port arbiter: width codes, FSM states,
// requester ids and the width-code to byte-count decode.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 17;

    localparam logic [2:0] WIDTH_B = 3'b001;
    localparam logic [2:0] WIDTH_H = 3'b010;
    localparam logic [2:0] WIDTH_W = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_MA = 1'b1
    } src_e;

    // Unknown width codes fall back to a full word.
    function automatic logic [2:0] width_to_n(input logic [2:0] w);
        case (w)
            WIDTH_B: return 3'd1;
            WIDTH_H: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_byte_seq.sv
// Byte sequencer: holds base address, length and byte counter, produces the
// current RAM address / write byte and assembles read bytes into a word.
module mem_byte_seq
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic              step,
    input  logic              capture,
    input  logic [31:0]       base_in,
    input  logic [2:0]        n_in,
    input  logic [31:0]       wdata_in,
    input  logic [7:0]        din,
    output logic [2:0]        cnt_o,
    output logic [2:0]        n_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        wbyte_o,
    output logic [31:0]       data_o
);

    logic [31:0] base_q, base_d;
    logic [2:0]  n_q, n_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic [31:0] data_next;

    // Byte arriving now belongs to the address issued one step earlier.
    always_comb begin
        data_next = data_q;
        if (capture) begin
            case (cnt_q)
                3'd1:    data_next[7:0]   = din;
                3'd2:    data_next[15:8]  = din;
                3'd3:    data_next[23:16] = din;
                default: data_next[31:24] = din;
            endcase
        end
    end

    always_comb begin
        base_d = base_q;
        n_d    = n_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        if (start) begin
            base_d = base_in;
            n_d    = n_in;
            cnt_d  = 3'd0;
            data_d = '0;
        end else if (step) begin
            cnt_d  = cnt_q + 3'd1;
            data_d = data_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            base_q <= '0;
            n_q    <= '0;
            cnt_q  <= '0;
            data_q <= '0;
        end else if (en) begin
            base_q <= base_d;
            n_q    <= n_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        case (cnt_q[1:0])
            2'd0:    wbyte_o = wdata_in[7:0];
            2'd1:    wbyte_o = wdata_in[15:8];
            2'd2:    wbyte_o = wdata_in[23:16];
            default: wbyte_o = wdata_in[31:24];
        endcase
    end

    assign addr_o = ADDR_W'(base_q + 32'(cnt_q));
    assign cnt_o  = cnt_q;
    assign n_o    = n_q;
    assign data_o = data_next;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the byte-wide RAM port between instruction fetch and the
// load/store unit; MA wins ties, fetches may be flushed mid-read.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              ma_re,
    input  logic              ma_we,
    input  logic [31:0]       ma_addr,
    input  logic [31:0]       ma_wdata,
    input  logic [2:0]        ma_width,
    output logic              ma_done,
    output logic [31:0]       ma_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic              stall_req_if,
    output logic              stall_req_ma
);

    state_e      state_q, state_d;
    src_e        src_q, src_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] ma_rdata_q, ma_rdata_d;

    logic              ma_any;
    logic              seq_start, seq_step, seq_capture;
    logic [31:0]       seq_base;
    logic [2:0]        seq_n_in, seq_cnt, seq_n;
    logic [ADDR_W-1:0] seq_addr;
    logic [7:0]        seq_wbyte;
    logic [31:0]       seq_data;
    logic              drive_a, wr, if_done_c, ma_done_c;

    assign ma_any = ma_re | ma_we;

    mem_byte_seq #(.ADDR_W(ADDR_W)) u_seq (
        .clk      (clk),
        .rst      (rst),
        .en       (rdy),
        .start    (seq_start),
        .step     (seq_step),
        .capture  (seq_capture),
        .base_in  (seq_base),
        .n_in     (seq_n_in),
        .wdata_in (ma_wdata),
        .din      (mem_din),
        .cnt_o    (seq_cnt),
        .n_o      (seq_n),
        .addr_o   (seq_addr),
        .wbyte_o  (seq_wbyte),
        .data_o   (seq_data)
    );

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        if_inst_d   = if_inst_q;
        ma_rdata_d  = ma_rdata_q;
        seq_start   = 1'b0;
        seq_step    = 1'b0;
        seq_capture = 1'b0;
        drive_a     = 1'b0;
        wr          = 1'b0;
        if_done_c   = 1'b0;
        ma_done_c   = 1'b0;
        seq_base    = ma_any ? ma_addr : if_addr;
        seq_n_in    = ma_any ? width_to_n(ma_width) : 3'd4;
        unique case (state_q)
            ST_IDLE: begin
                if (ma_any || if_req) begin
                    seq_start = 1'b1;
                    src_d     = ma_any ? SRC_MA : SRC_IF;
                    state_d   = ma_we ? ST_WR : ST_RD;
                end
            end
            // One extra RD cycle after the last address collects the final byte.
            ST_RD: begin
                seq_step    = 1'b1;
                seq_capture = (seq_cnt != 3'd0);
                drive_a     = (seq_cnt != seq_n);
                if (src_q == SRC_IF && if_flush) begin
                    state_d = ST_IDLE;
                end else if (seq_cnt == seq_n) begin
                    state_d = ST_DONE;
                    if (src_q == SRC_IF) if_inst_d  = seq_data;
                    else                 ma_rdata_d = seq_data;
                end
            end
            ST_WR: begin
                seq_step = 1'b1;
                drive_a  = 1'b1;
                wr       = 1'b1;
                if (seq_cnt == seq_n - 3'd1) state_d = ST_DONE;
            end
            ST_DONE: begin
                if_done_c = (src_q == SRC_IF);
                ma_done_c = (src_q == SRC_MA);
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_IF;
            if_inst_q  <= '0;
            ma_rdata_q <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            src_q      <= src_d;
            if_inst_q  <= if_inst_d;
            ma_rdata_q <= ma_rdata_d;
        end
    end

    // Writes are suppressed while frozen or in reset so no stray byte lands.
    assign mem_a        = drive_a ? seq_addr : '0;
    assign mem_dout     = wr ? seq_wbyte : 8'h00;
    assign mem_wr       = wr & rdy & rst;
    assign if_done      = if_done_c & rdy;
    assign ma_done      = ma_done_c & rdy;
    assign if_inst      = if_inst_q;
    assign ma_rdata     = ma_rdata_q;
    assign stall_req_if = if_req & ~if_done;
    assign stall_req_ma = ma_any & ~ma_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter with a byte-array RAM model.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 17;
    localparam int MEM_SZ = 1 << ADDR_W;

    logic              clk = 1'b0, rst = 1'b0, rdy = 1'b1;
    logic              if_req = 1'b0, if_flush = 1'b0, ma_re = 1'b0, ma_we = 1'b0;
    logic [31:0]       if_addr = '0, ma_addr = '0, ma_wdata = '0;
    logic [2:0]        ma_width = 3'b100;
    logic [7:0]        mem_din = '0;
    logic              if_done, ma_done, mem_wr, stall_req_if, stall_req_ma;
    logic [31:0]       if_inst, ma_rdata;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;

    mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_inst(if_inst),
        .ma_re(ma_re), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
        .ma_width(ma_width), .ma_done(ma_done), .ma_rdata(ma_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .stall_req_if(stall_req_if), .stall_req_ma(stall_req_ma)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37) ^ (i >> 5) ^ 8'h5A);
    endfunction

    // RAM environment: read data registered, frozen together with the core when rdy=0.
    logic [7:0]        ram [MEM_SZ];
    logic [7:0]        ref_mem [MEM_SZ];
    bit                ram_init = 1'b0;
    logic              poke_en = 1'b0;
    logic [ADDR_W-1:0] poke_addr = '0;
    logic [7:0]        poke_data = '0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < MEM_SZ; i++) ram[i] <= init_byte(i);
            ram_init <= 1'b1;
        end else begin
            if (poke_en) ram[poke_addr] <= poke_data;
            if (mem_wr) ram[mem_a] <= mem_dout;
            if (rdy) mem_din <= ram[mem_a];
        end
    end

    bit rdy_rand = 1'b0;
    int lo_start = -1, lo_end = -1;
    always @(posedge clk) begin
        #2;
        rdy = !(cyc >= lo_start && cyc < lo_end) && (!rdy_rand || $urandom_range(0, 7) != 0);
    end

    typedef struct {
        bit          store;
        logic [31:0] addr;
        int          n;
        logic [31:0] data;
        int          due;
    } exp_t;
    typedef struct {
        string       name;
        logic [31:0] got;
        logic [31:0] exp;
    } chk_t;

    exp_t if_q[$], ma_q[$];
    chk_t chk_q[$];
    chk_t c;
    int   errors = 0, checks = 0, hi_cnt = 0, busy = 0;

    task automatic check_done(input bit is_if);
        exp_t        e;
        logic [31:0] got;
        checks++;
        if ((is_if ? if_q.size() : ma_q.size()) == 0) begin
            errors++;
            $display("FAIL %s_unexpected_done: done=1 required 0", is_if ? "if" : "ma");
            return;
        end
        e = is_if ? if_q.pop_front() : ma_q.pop_front();
        if (hi_cnt != e.due) begin
            errors++;
            $display("FAIL %s_latency @0x%0h: done at step %0d required %0d",
                     is_if ? "if" : "ma", e.addr, hi_cnt, e.due);
        end
        got = '0;
        if (e.store) for (int i = 0; i < e.n; i++) got[8*i +: 8] = ram[ADDR_W'(e.addr + 32'(i))];
        else         got = is_if ? if_inst : ma_rdata;
        checks++;
        if (got !== e.data) begin
            errors++;
            $display("FAIL %s_%s_data @0x%0h: got 0x%08h required 0x%08h",
                     is_if ? "if" : "ma", e.store ? "store" : "load", e.addr, got, e.data);
        end
        checks++;
        if ((is_if ? stall_req_if : stall_req_ma) !== 1'b0) begin
            errors++;
            $display("FAIL %s_stall_at_done: got 1 required 0", is_if ? "if" : "ma");
        end
    endtask

    always @(negedge clk) begin
        if (rdy) hi_cnt++;
        if (ma_re || ma_we || if_req) busy++;
        else busy = 0;
        if (busy == 200) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout: request pending %0d cycles, required done", busy);
        end
        if (!rdy) begin
            checks++;
            if (mem_wr !== 1'b0) begin
                errors++;
                $display("FAIL frozen_mem_wr: got %b required 0", mem_wr);
            end
        end
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            checks++;
            if (c.got !== c.exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h required 0x%0h", c.name, c.got, c.exp);
            end
        end
        if (if_done) check_done(1'b1);
        if (ma_done) check_done(1'b0);
    end

    // ---------------- reference model ----------------
    function automatic int n_of(input logic [2:0] w);
        return (w == 3'b001) ? 1 : (w == 3'b010) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
        logic [31:0] d = '0;
        for (int i = 0; i < n; i++) d[8*i +: 8] = ref_mem[ADDR_W'(a + 32'(i))];
        return d;
    endfunction

    task automatic post(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_t k;
        k.name = name; k.got = got; k.exp = exp;
        chk_q.push_back(k);
    endtask

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        poke_en = 1'b1; poke_addr = a; poke_data = d; ref_mem[a] = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic wait_reqs();
        int guard = 0;
        while ((ma_re || ma_we || if_req) && guard < 250) begin
            @(negedge clk);
            guard++;
            if (ma_done) begin ma_re = 1'b0; ma_we = 1'b0; end
            if (if_done) if_req = 1'b0;
        end
        ma_re = 1'b0; ma_we = 1'b0; if_req = 1'b0;
    endtask

    task automatic run_txn(input bit do_ma, input bit we, input bit re_too,
                           input logic [31:0] maddr, input logic [31:0] wd, input logic [2:0] w,
                           input bit do_if, input logic [31:0] iaddr,
                           input int lo_off, input int lo_len);
        exp_t e;
        int   base, k_ma, n;
        @(posedge clk); #1;
        if (lo_len > 0) begin lo_start = cyc + lo_off; lo_end = lo_start + lo_len; end
        base = hi_cnt;
        k_ma = 0;
        if (do_ma) begin
            n = n_of(w);
            e.store = we; e.addr = maddr; e.n = n;
            if (we) begin
                e.data = '0;
                for (int i = 0; i < n; i++) begin
                    e.data[8*i +: 8] = wd[8*i +: 8];
                    ref_mem[ADDR_W'(maddr + 32'(i))] = wd[8*i +: 8];
                end
                k_ma = n + 2;
            end else begin
                e.data = ref_load(maddr, n);
                k_ma = n + 3;
            end
            e.due = base + k_ma;
            ma_q.push_back(e);
            ma_addr = maddr; ma_wdata = wd; ma_width = w; ma_we = we; ma_re = !we || re_too;
        end
        if (do_if) begin
            e.store = 1'b0; e.addr = iaddr; e.n = 4; e.data = ref_load(iaddr, 4);
            e.due = base + k_ma + (do_ma ? 7 : 7);
            if_q.push_back(e);
            if_addr = iaddr; if_req = 1'b1;
        end
        wait_reqs();
    endtask

    initial begin
        exp_t        e;
        int          base;
        logic [31:0] a;
        for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = init_byte(i);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        post("rst_if_inst", if_inst, 32'h0);
        post("rst_ma_rdata", ma_rdata, 32'h0);
        post("rst_mem_a", 32'(mem_a), 32'h0);
        post("rst_bus", {mem_dout, 4'h0, if_done, ma_done, mem_wr, stall_req_if}, 32'h0);

        // fetch of a known word
        poke(17'h100, 8'h13); poke(17'h101, 8'h57); poke(17'h102, 8'h9B); poke(17'h103, 8'hDF);
        run_txn(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b100, 1'b1, 32'h100, 0, 0);
        post("t1_if_inst", if_inst, 32'hDF9B5713);

        // simultaneous fetch and byte load: load goes first
        poke(17'h20, 8'h80);
        run_txn(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 3'b001, 1'b1, 32'h100, 0, 0);
        post("t2_ma_rdata", ma_rdata, 32'h00000080);

        // half store straddling the top of the address space
        run_txn(1'b1, 1'b1, 1'b0, 32'h0001FFFF, 32'hABCD1234, 3'b010, 1'b0, 32'h0, 0, 0);
        post("t3_wrap_lo", 32'(ram[17'h1FFFF]), 32'h34);
        post("t3_wrap_hi", 32'(ram[17'h00000]), 32'h12);

        // fetch flushed in its third cycle, new fetch accepted right after
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h200;
        repeat (3) begin @(posedge clk); #1; end
        if_flush = 1'b1; if_req = 1'b0;
        @(posedge clk); #1;
        if_flush = 1'b0;
        base = hi_cnt;
        e.store = 1'b0; e.addr = 32'h100; e.n = 4; e.data = ref_load(32'h100, 4); e.due = base + 7;
        if_q.push_back(e);
        if_addr = 32'h100; if_req = 1'b1;
        wait_reqs();
        post("t4_if_inst", if_inst, 32'hDF9B5713);

        // word load frozen for two cycles in the middle
        run_txn(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 3'b100, 1'b0, 32'h0, 2, 2);

        // reset during a word store: only the first byte lands
        @(posedge clk); #1;
        ma_we = 1'b1; ma_addr = 32'h400; ma_wdata = 32'h11223344; ma_width = 3'b100;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0; ma_we = 1'b0;
        @(posedge clk); #1;
        post("t6_mem_a", 32'(mem_a), 32'h0);
        post("t6_bus", {mem_dout, 4'h0, if_done, ma_done, mem_wr, stall_req_ma}, 32'h0);
        post("t6_outs", if_inst | ma_rdata, 32'h0);
        rst = 1'b1;
        ref_mem[17'h400] = 8'h44;
        run_txn(1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 3'b100, 1'b0, 32'h0, 0, 0);

        // random traffic with random rdy stalls
        rdy_rand = 1'b1;
        for (int t = 0; t < 120; t++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[16:0] = 17'h1FFFC + 17'($urandom_range(0, 3));
            run_txn(kind != 0, kind == 2 || (kind == 3 && $urandom_range(0, 1) == 1),
                    1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)),
                    kind == 0 || kind == 3, $urandom, 0, 0);
        end
        rdy_rand = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (if_q.size() != 0 || ma_q.size() != 0) begin
            errors++;
            $display("FAIL missing_done: %0d if / %0d ma pending, required 0", if_q.size(), ma_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
